// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Wide enough for RD_LATENCY-1 with RD_LATENCY up to 4.
  localparam int unsigned CNT_W = 2;

  // Full-word stores must be word aligned; half-word masks must be half aligned.
  function automatic logic store_misaligned(input logic [3:0] mask, input logic [1:0] off);
    return ((mask == 4'b1111) && (off != 2'b00)) ||
           (((mask == 4'b0011) || (mask == 4'b1100)) && off[0]);
  endfunction

  // Misaligned half/word loads and unassigned load codes are both errors.
  function automatic logic load_illegal(input logic [2:0] ctrl, input logic [1:0] off);
    logic bad;
    case (ctrl)
      LD_B, LD_BU: bad = 1'b0;
      LD_H, LD_HU: bad = off[0];
      LD_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_load_aligner.sv
// Selects the addressed byte/halfword lane of a read word and extends it.
module load_aligner
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  load_ctrl,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  b;
  logic [15:0] h;

  // Lane select, then sign/zero extension; illegal requests return zero.
  always_comb begin
    b       = word[8*off +: 8];
    h       = word[16*off[1] +: 16];
    illegal = load_illegal(load_ctrl, off);
    data    = '0;
    if (!illegal) begin
      case (load_ctrl)
        LD_B:    data = {{24{b[7]}}, b};
        LD_BU:   data = {24'h0, b};
        LD_H:    data = {{16{h[15]}}, h};
        LD_HU:   data = {16'h0, h};
        LD_W:    data = word;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: byte-masked stores, extended loads, one request at a time.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_mask,
  input  logic [2:0]        req_load_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx;
  logic             accept, store_err, load_err;
  logic [1:0]       off_q;
  logic [2:0]       ctrl_q;
  logic             we_q, err_q;
  logic [31:0]      word_q;
  logic [31:0]      ld_data;
  logic             ld_illegal;
  logic             unused_addr;

  assign idx         = req_addr[2 +: IDX_W];
  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];
  assign accept      = req_valid && req_ready;
  assign store_err   = store_misaligned(req_mask, req_addr[1:0]);
  assign load_err    = load_illegal(req_load_ctrl, req_addr[1:0]);

  // Commit enabled bytes of an error-free store in the accept cycle; array is not reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !store_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_mask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Capture the request context and raw read word at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      ctrl_q <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      word_q <= '0;
    end else if (accept) begin
      off_q  <= req_addr[1:0];
      ctrl_q <= req_load_ctrl;
      we_q   <= req_we;
      err_q  <= req_we ? store_err : load_err;
      word_q <= req_we ? '0 : mem[idx];
    end
  end

  load_aligner u_align (
    .word      (word_q),
    .off       (off_q),
    .load_ctrl (ctrl_q),
    .data      (ld_data),
    .illegal   (ld_illegal)
  );

  // Extraction runs on the captured word, so the response stays stable under backpressure.
  always_comb begin
    rsp_rdata = we_q ? '0 : ld_data;
    rsp_err   = err_q | (!we_q & ld_illegal);
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and handshake outputs; RESP is entered as the wait count reaches zero.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (RD_LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            cnt_nx   = CNT_W'(RD_LATENCY - 1);
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one latency-1 and one latency-3 responder.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic [2:0]  req_load_ctrl = '0;
  logic        v1 = 1'b0, v3 = 1'b0, rk1 = 1'b0, rk3 = 1'b0;
  logic        rr1, rr3, rv1, rv3, re1, re3;
  logic [31:0] rd1, rd3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_load_ctrl(req_load_ctrl), .rsp_valid(rv1), .rsp_ready(rk1),
    .rsp_rdata(rd1), .rsp_err(re1)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rr3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_load_ctrl(req_load_ctrl), .rsp_valid(rv3), .rsp_ready(rk3),
    .rsp_rdata(rd3), .rsp_err(re3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; latency counts cycles from accept edge to rsp_valid.
  task automatic xact(input bit sel3, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask, input logic [2:0] ctrl,
                      output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_mask = mask; req_load_ctrl = ctrl;
    if (sel3) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    lat = 1;
    while (!(sel3 ? rv3 : rv1) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = sel3 ? rd3 : rd1;
    err   = sel3 ? re3 : re1;
    if (sel3) rk3 = 1'b1; else rk1 = 1'b1;
    @(posedge clk); #1;
    rk1 = 1'b0; rk3 = 1'b0;
  endtask

  task automatic st(input bit sel3, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] mask, input logic exp_e, input string tag);
    logic [31:0] d; logic e; int l;
    xact(sel3, 1'b1, addr, wdata, mask, 3'b000, d, e, l);
    chk({tag, ".err"}, 32'(e), 32'(exp_e));
    chk({tag, ".rdata"}, d, 32'h0);
    chk({tag, ".lat"}, 32'(l), sel3 ? 32'd3 : 32'd1);
  endtask

  task automatic ld(input bit sel3, input logic [31:0] addr, input logic [2:0] ctrl,
                    input logic [31:0] exp_d, input logic exp_e, input string tag);
    logic [31:0] d; logic e; int l;
    xact(sel3, 1'b0, addr, 32'h0, 4'h0, ctrl, d, e, l);
    chk({tag, ".rdata"}, d, exp_d);
    chk({tag, ".err"}, 32'(e), 32'(exp_e));
    chk({tag, ".lat"}, 32'(l), sel3 ? 32'd3 : 32'd1);
  endtask

  initial begin
    #12;
    chk("rst.req_ready1", 32'(rr1), 32'd1);
    chk("rst.rsp_valid1", 32'(rv1), 32'd0);
    chk("rst.rdata1", rd1, 32'h0);
    chk("rst.err1", 32'(re1), 32'd0);
    chk("rst.req_ready3", 32'(rr3), 32'd1);
    chk("rst.rsp_valid3", 32'(rv3), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    st(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "st_w10");
    ld(0, 32'h10, LD_W, 32'hDEADBEEF, 1'b0, "lw10");

    st(0, 32'h10, 32'h0, 4'hF, 1'b0, "clr10");
    st(0, 32'h12, 32'h0080_0000, 4'b0100, 1'b0, "sb12");
    ld(0, 32'h12, LD_B,  32'hFFFF_FF80, 1'b0, "lb12");
    ld(0, 32'h12, LD_BU, 32'h0000_0080, 1'b0, "lbu12");
    ld(0, 32'h10, LD_W,  32'h0080_0000, 1'b0, "lw10b");

    st(0, 32'h22, 32'h8001_0000, 4'b1100, 1'b0, "sh22");
    ld(0, 32'h22, LD_H,  32'hFFFF_8001, 1'b0, "lh22");
    ld(0, 32'h22, LD_HU, 32'h0000_8001, 1'b0, "lhu22");
    ld(0, 32'h21, LD_H,  32'h0, 1'b1, "lh21_mis");
    ld(0, 32'h23, LD_HU, 32'h0, 1'b1, "lhu23_mis");

    st(0, 32'h30, 32'h1234_5678, 4'hF, 1'b0, "sw30");
    st(0, 32'h31, 32'hAAAA_AAAA, 4'hF, 1'b1, "sw31_mis");
    st(0, 32'h31, 32'hBBBB_BBBB, 4'b0011, 1'b1, "sh31_mis");
    st(0, 32'h30, 32'hCCCC_CCCC, 4'b0000, 1'b0, "nop30");
    ld(0, 32'h30, LD_W,  32'h1234_5678, 1'b0, "lw30");
    ld(0, 32'h31, LD_B,  32'h0000_0056, 1'b0, "lb31");
    ld(0, 32'h33, LD_B,  32'h0000_0012, 1'b0, "lb33");
    ld(0, 32'h30, LD_H,  32'h0000_5678, 1'b0, "lh30");
    ld(0, 32'h32, LD_HU, 32'h0000_1234, 1'b0, "lhu32");
    ld(0, 32'h32, LD_W,  32'h0, 1'b1, "lw32_mis");
    ld(0, 32'h30, 3'b111, 32'h0, 1'b1, "ctrl111");
    ld(0, 32'h30, 3'b101, 32'h0, 1'b1, "ctrl101");
    ld(0, 32'h1030, LD_W, 32'h1234_5678, 1'b0, "lw_wrap");

    // Latency-3 responder: backpressure with the response held.
    st(1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, "sw40_l3");
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40; req_load_ctrl = LD_W; v3 = 1'b1;
    chk("bp.ready_before", 32'(rr3), 32'd1);
    @(posedge clk); #1; v3 = 1'b0;
    chk("bp.c1.valid", 32'(rv3), 32'd0);
    chk("bp.c1.ready", 32'(rr3), 32'd0);
    @(posedge clk); #1;
    chk("bp.c2.valid", 32'(rv3), 32'd0);
    @(posedge clk); #1;
    chk("bp.c3.valid", 32'(rv3), 32'd1);
    chk("bp.c3.rdata", rd3, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold.valid", 32'(rv3), 32'd1);
      chk("bp.hold.rdata", rd3, 32'hCAFE_F00D);
      chk("bp.hold.ready", 32'(rr3), 32'd0);
    end
    @(negedge clk); rk3 = 1'b1;
    @(posedge clk); #1; rk3 = 1'b0;
    chk("bp.after.valid", 32'(rv3), 32'd0);
    chk("bp.after.ready", 32'(rr3), 32'd1);

    // Reset while waiting: response dropped, memory retained.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40; req_load_ctrl = LD_W; v3 = 1'b1;
    @(posedge clk); #1; v3 = 1'b0;
    chk("rstw.in_wait.ready", 32'(rr3), 32'd0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rstw.valid", 32'(rv3), 32'd0);
    chk("rstw.ready", 32'(rr3), 32'd1);
    chk("rstw.rdata", rd3, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstw.no_replay", 32'(rv3), 32'd0);
    end
    ld(1, 32'h40, LD_W, 32'hCAFE_F00D, 1'b0, "lw40_after_rst");
    ld(0, 32'h30, LD_W, 32'h1234_5678, 1'b0, "lw30_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
